seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 100000, clock cycles per digit slot.
REQ-002 SHALL provide parameter GUARD_CYC, default 100, all-off cycles at the start of each slot; legal range 1 <= GUARD_CYC <= CLK_DIV-2.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: load  in  1  request to capture a new display word.
REQ-007 Port: value  in  32  eight hex nibbles; digit i = value[4i+3:4i].
REQ-008 Port: dp_mask  in  8  bit i=1 lights the decimal point of digit i.
REQ-009 Port: blank_mask  in  8  bit i=1 blanks digit i.
REQ-010 Port: ready  out  1  high when a load will be accepted.
REQ-011 Port: an  out  8  active-low digit enables; bit i = digit i.
REQ-012 Port: seg  out  8  active-low segments; bit7=dp, bits6..0 = g..a.

Function
REQ-013 Slot counter SHALL run 0..CLK_DIV-1, then wrap to 0 and advance the digit index 0..7, which wraps 7->0.
REQ-014 State machine SHALL have two states, each lasting the stated number of cycles:
- GUARD: counter < GUARD_CYC; an=8'hFF, seg=8'hFF.
- DRIVE: remaining cycles of the slot; only an[digit] is low.
REQ-015 Frame boundary SHALL be the cycle on which the counter wraps with digit=7.
REQ-016 In DRIVE, seg[6:0] SHALL be the hex pattern of the active nibble from the displayed shadow:
- 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000
- 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000
- 8=000_0000, 9=001_0000, A=000_1000, b=000_0011
- C=100_0110, d=010_0001, E=000_0110, F=000_1110
REQ-017 In DRIVE, seg[7] SHALL be 0 if shadow dp_mask[digit] is set, else 1.
REQ-018 In DRIVE, blank_mask[digit]=1 SHALL force seg=8'hFF, with an still asserted for that digit.
REQ-019 an and seg SHALL be registered: the values for counter/digit state at cycle k appear at cycle k+1.
REQ-020 Handshake: load && ready SHALL capture value, dp_mask and blank_mask into a pending register, and ready SHALL be 0 from the next cycle.
REQ-021 load while ready=0 SHALL be ignored, with no effect on the pending register.
REQ-022 At a frame boundary with pending valid, pending SHALL copy to the shadow, so the new word is shown from digit 0 of the next frame; ready SHALL return to 1 on the following cycle.
REQ-023 If load is accepted on the frame-boundary cycle itself, that word SHALL NOT apply at this boundary; it is applied at the next boundary.
REQ-024 The shadow register SHALL change only at frame boundaries, so no frame shows mixed words.

Reset
REQ-025 On rst SHALL set: an=8'hFF, seg=8'hFF, ready=1, digit=0, counter=0, state=GUARD, shadow value/dp/blank=0, pending cleared.
REQ-026 rst asserted mid-slot or with pending valid SHALL discard the pending word; rst SHALL take priority over a simultaneous load.

Structure
REQ-027 Shared package SHALL hold: the 16-entry hex segment table, SEG_OFF=8'hFF, AN_OFF=8'hFF, NUM_DIGITS=8, and the state encoding.
REQ-028 Sub-module seg_refresh_timer SHALL contain the slot counter and digit index, and output slot_wrap, frame_wrap, in_guard and digit[2:0].

Verification (CLK_DIV=8, GUARD_CYC=2, frame = 64 cycles)
REQ-029 Reset, then load 32'h0123_4567, dp=0, blank=0 -> from the next frame: digit0 DRIVE shows an=8'hFE, seg=8'hF8; digit7 shows an=8'h7F, seg=8'hC0.
REQ-030 Load 32'h89AB_CDEF -> digit0 seg=8'h8E; digit4 seg=8'h83; digit7 seg=8'h80.
REQ-031 Load with dp_mask=8'h01, blank_mask=8'h80, value=0 -> digit0 seg=8'h40; digit7 an=8'h7F, seg=8'hFF.
REQ-032 Handshake:
- load at cycle 20 of a frame -> ready=0 at cycle 21.
- Second load at cycle 30 -> ignored.
- New word appears at next frame digit0; ready=1 one cycle after the boundary.
- Load on the boundary cycle itself -> applied one frame later.
REQ-033 Guard timing: every slot has exactly 2 cycles of an=8'hFF, seg=8'hFF followed by 6 DRIVE cycles; digit order 0..7 then wrap to 0.
REQ-034 Reset mid-frame with pending valid:
- Next cycle: an=8'hFF, seg=8'hFF, ready=1.
- After the 2 guard cycles, digit0 shows seg=8'hC0 (shadow 0).

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, segment table and scan-state encoding for the
// eight-digit multiplexed seven-segment display controller.
package seg_scan_ctrl_pkg;

  localparam int          NUM_DIGITS = 8;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [7:0]  AN_OFF     = 8'hFF;

  // Active-low g..a patterns, index = hex nibble (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b000_1110,  // F
    7'b000_0110,  // E
    7'b010_0001,  // d
    7'b100_0110,  // C
    7'b000_0011,  // b
    7'b000_1000,  // A
    7'b001_0000,  // 9
    7'b000_0000,  // 8
    7'b111_1000,  // 7
    7'b000_0010,  // 6
    7'b001_0010,  // 5
    7'b001_1001,  // 4
    7'b011_0000,  // 3
    7'b010_0100,  // 2
    7'b111_1001,  // 1
    7'b100_0000   // 0
  };

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// Slot counter and digit index for the display scan.
// in_guard describes the slot position entered on the coming edge, so the
// controller's registered state lines up with the counter cycle for cycle.
module seg_refresh_timer
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 100000,
  parameter int GUARD_CYC = 100
) (
  input  logic       clk,
  input  logic       rst,
  output logic       slot_wrap,
  output logic       frame_wrap,
  output logic       in_guard,
  output logic [2:0] digit
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign slot_wrap  = (cnt == CW'(CLK_DIV - 1));
  assign frame_wrap = slot_wrap && (digit == 3'(NUM_DIGITS - 1));
  assign cnt_nxt    = slot_wrap ? '0 : cnt + CW'(1);
  assign in_guard   = (cnt_nxt < CW'(GUARD_CYC));

  // Counter runs 0..CLK_DIV-1; digit advances (and wraps 7->0) on each slot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      digit <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (slot_wrap) digit <= digit + 3'd1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a one-deep
// load buffer; new words are swapped in only at frame boundaries.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 100000,
  parameter int GUARD_CYC = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  output logic        ready,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  logic       slot_wrap, frame_wrap, in_guard;
  logic [2:0] digit;

  seg_refresh_timer #(
    .CLK_DIV   (CLK_DIV),
    .GUARD_CYC (GUARD_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .slot_wrap  (slot_wrap),
    .frame_wrap (frame_wrap),
    .in_guard   (in_guard),
    .digit      (digit)
  );

  logic        pend_vld;
  logic [31:0] pend_val;
  logic [7:0]  pend_dp, pend_blank;
  logic [31:0] shad_val;
  logic [7:0]  shad_dp, shad_blank;

  assign ready = !pend_vld;

  // Pending capture on handshake; pending -> shadow only at a frame boundary.
  // A word accepted on the boundary cycle itself waits for the next one,
  // since pend_vld was still clear when the boundary was evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld   <= 1'b0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      shad_val   <= '0;
      shad_dp    <= '0;
      shad_blank <= '0;
    end else begin
      if (frame_wrap && pend_vld) begin
        shad_val   <= pend_val;
        shad_dp    <= pend_dp;
        shad_blank <= pend_blank;
        pend_vld   <= 1'b0;
      end
      if (load && ready) begin
        pend_val   <= value;
        pend_dp    <= dp_mask;
        pend_blank <= blank_mask;
        pend_vld   <= 1'b1;
      end
    end
  end

  scan_state_t state_q, state_d;
  logic [7:0]  an_d, seg_d;

  // Scan FSM register and registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_GUARD;
      an      <= AN_OFF;
      seg     <= SEG_OFF;
    end else begin
      state_q <= state_d;
      an      <= an_d;
      seg     <= seg_d;
    end
  end

  // Next state from the timer; pin values decoded from the current state.
  always_comb begin
    state_d = state_q;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    case (state_q)
      ST_GUARD: begin
        if (!in_guard) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        an_d = ~(8'd1 << digit);
        if (!shad_blank[digit])
          seg_d = {~shad_dp[digit], hex_seg(shad_val[{digit, 2'b00} +: 4])};
        if (in_guard) state_d = ST_GUARD;
      end
      default: state_d = ST_GUARD;
    endcase
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl (CLK_DIV=8, GUARD_CYC=2).
// The reference model tracks the frame position as a plain 0..63 number and
// derives digit/slot phase arithmetically.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = DIV * 8;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dp_mask, blank_mask;
  logic        ready;
  logic [7:0]  an, seg;

  seg_scan_ctrl #(.CLK_DIV(DIV), .GUARD_CYC(GUARD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .ready      (ready),
    .an         (an),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  int          m_t;
  bit          m_pv;
  bit [31:0]   m_pval, m_sval;
  bit [7:0]    m_pdp, m_pbl, m_sdp, m_sbl;
  bit [7:0]    m_an, m_seg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  // Advance the reference model across one rising edge using current inputs.
  task automatic model_step();
    int  d, c;
    bit  acc;
    if (rst) begin
      m_t = 0; m_pv = 0;
      m_pval = '0; m_pdp = '0; m_pbl = '0;
      m_sval = '0; m_sdp = '0; m_sbl = '0;
      m_an = 8'hFF; m_seg = 8'hFF;
    end else begin
      d = m_t / DIV;
      c = m_t % DIV;
      if (c < GUARD) begin
        m_an = 8'hFF; m_seg = 8'hFF;
      end else begin
        m_an = ~(8'(1) << d);
        if (m_sbl[d]) m_seg = 8'hFF;
        else m_seg = {~m_sdp[d], hex_tab[(m_sval >> (4 * d)) & 32'hF]};
      end
      acc = load && !m_pv;
      if (m_t == FRAME - 1 && m_pv) begin
        m_sval = m_pval; m_sdp = m_pdp; m_sbl = m_pbl; m_pv = 0;
      end
      if (acc) begin
        m_pval = value; m_pdp = dp_mask; m_pbl = blank_mask; m_pv = 1;
      end
      m_t = (m_t + 1) % FRAME;
    end
  endtask

  // One clock: drive inputs, step the model, then check all outputs mid-cycle.
  task automatic cyc(input logic l, input logic [31:0] v, input logic [7:0] d,
                     input logic [7:0] b, input logic r);
    load = l; value = v; dp_mask = d; blank_mask = b; rst = r;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("an", an, m_an);
    chk("seg", seg, m_seg);
    chk("ready", ready, !m_pv);
  endtask

  task automatic idle();
    cyc(1'b0, $urandom, 8'($urandom), 8'($urandom), 1'b0);
  endtask

  // Idle until the model's frame position equals pos (bounded).
  task automatic run_to(input int pos);
    int n = 0;
    while (m_t != pos && n < 2 * FRAME) begin
      idle();
      n++;
    end
    if (m_t != pos) chk("run_to_timeout", 32'(m_t), 32'(pos));
  endtask

  initial begin
    load = 0; value = 0; dp_mask = 0; blank_mask = 0; rst = 1;
    @(negedge clk);
    cyc(1'b0, 32'h0, 8'h0, 8'h0, 1'b1);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_ready", ready, 1'b1);

    // basic word, shown from the next frame
    cyc(1'b1, 32'h0123_4567, 8'h00, 8'h00, 1'b0);
    run_to(0); run_to(3);
    chk("w1_d0_an", an, 8'hFE);
    chk("w1_d0_seg", seg, 8'hF8);
    run_to(63);
    chk("w1_d7_an", an, 8'h7F);
    chk("w1_d7_seg", seg, 8'hC0);

    // load on the boundary cycle: not applied until one frame later
    cyc(1'b1, 32'h89AB_CDEF, 8'h00, 8'h00, 1'b0);
    run_to(3);
    chk("bnd_not_yet", seg, 8'hF8);
    run_to(0); run_to(3);
    chk("w2_d0_seg", seg, 8'h8E);
    run_to(35);
    chk("w2_d4_seg", seg, 8'h83);
    run_to(63);
    chk("w2_d7_seg", seg, 8'h80);

    // dp and blank masks
    run_to(5);
    cyc(1'b1, 32'h0, 8'h01, 8'h80, 1'b0);
    run_to(0); run_to(3);
    chk("w3_d0_seg", seg, 8'h40);
    run_to(63);
    chk("w3_d7_an", an, 8'h7F);
    chk("w3_d7_seg", seg, 8'hFF);

    // handshake: busy after accept, second load ignored
    run_to(20);
    cyc(1'b1, 32'h0000_000A, 8'h00, 8'h00, 1'b0);
    chk("hs_busy", ready, 1'b0);
    run_to(30);
    cyc(1'b1, 32'h0000_0005, 8'h00, 8'h00, 1'b0);
    run_to(63);
    chk("hs_still_busy", ready, 1'b0);
    idle();
    chk("hs_ready_back", ready, 1'b1);
    run_to(3);
    chk("hs_word_seg", seg, 8'h88);

    // reset mid-frame with a pending word
    run_to(10);
    cyc(1'b1, 32'h1234_5678, 8'hFF, 8'h00, 1'b0);
    idle();
    cyc(1'b0, 32'h0, 8'h0, 8'h0, 1'b1);
    chk("mrst_an", an, 8'hFF);
    chk("mrst_seg", seg, 8'hFF);
    chk("mrst_ready", ready, 1'b1);
    run_to(3);
    chk("mrst_d0_an", an, 8'hFE);
    chk("mrst_d0_seg", seg, 8'hC0);

    // random traffic, including reset racing load
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 5) == 0), $urandom, 8'($urandom), 8'($urandom),
          ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
